// File: rtl/id_control_unit.sv
// Decode-stage control and hazard sequencer for a 5-stage RV32I pipeline.
// Holds the ID/EX control word, detects load-use hazards and tracks illegal opcodes.
module id_control_unit #(
   parameter int ALUC_W   = 3,
   parameter int ILLCNT_W = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [31:0]         InstrD,
   input  logic                PCSrcE,
   output logic [1:0]          ImmSrcD,
   output logic                IllegalD,
   output logic                StallF,
   output logic                StallD,
   output logic                FlushD,
   output logic                FlushE,
   output logic                RegWriteE,
   output logic [1:0]          ResultSrcE,
   output logic                MemWriteE,
   output logic                JumpE,
   output logic                BranchE,
   output logic                ALUSrcE,
   output logic [ALUC_W-1:0]   ALUControlE,
   output logic [4:0]          Rs1E,
   output logic [4:0]          Rs2E,
   output logic [4:0]          RdE,
   output logic                IllegalSeen,
   output logic [ILLCNT_W-1:0] IllegalCnt
);

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_B   = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [ALUC_W-1:0] ALU_ADD = ALUC_W'(3'b000);
   localparam logic [ALUC_W-1:0] ALU_SUB = ALUC_W'(3'b001);
   localparam logic [ALUC_W-1:0] ALU_AND = ALUC_W'(3'b010);
   localparam logic [ALUC_W-1:0] ALU_OR  = ALUC_W'(3'b011);
   localparam logic [ALUC_W-1:0] ALU_SLT = ALUC_W'(3'b101);

   localparam logic [ILLCNT_W-1:0] CNT_MAX = {ILLCNT_W{1'b1}};

   logic [6:0]        op_s;
   logic [2:0]        f3_s;
   logic              f7b5_s;
   logic [4:0]        rs1_s;
   logic [4:0]        rs2_s;
   logic [4:0]        rd_s;
   logic [ALUC_W-1:0] alu_f3_s;
   logic              f3_ok_s;
   logic              regwrite_s;
   logic [1:0]        resultsrc_s;
   logic              memwrite_s;
   logic              jump_s;
   logic              branch_s;
   logic              alusrc_s;
   logic [ALUC_W-1:0] aluctl_s;
   logic [1:0]        immsrc_s;
   logic              illegal_s;
   logic              use_rs1_s;
   logic              use_rs2_s;
   logic              lwstall_s;
   logic              flushe_s;
   logic              unused_s;

   assign op_s     = InstrD[6:0];
   assign f3_s     = InstrD[14:12];
   assign f7b5_s   = InstrD[30];
   assign rs1_s    = InstrD[19:15];
   assign rs2_s    = InstrD[24:20];
   assign rd_s     = InstrD[11:7];
   assign unused_s = ^{InstrD[31], InstrD[29:25]};

   // Shared ALU operation selected by funct3 for R and I formats
   always_comb begin
      alu_f3_s = ALU_ADD;
      f3_ok_s  = 1'b1;
      case (f3_s)
         3'b000:  alu_f3_s = ALU_ADD;
         3'b010:  alu_f3_s = ALU_SLT;
         3'b110:  alu_f3_s = ALU_OR;
         3'b111:  alu_f3_s = ALU_AND;
         default: f3_ok_s  = 1'b0;
      endcase
   end

   // Main decoder: unsupported encodings leave every control bit at zero
   always_comb begin
      regwrite_s  = 1'b0;
      resultsrc_s = 2'b00;
      memwrite_s  = 1'b0;
      jump_s      = 1'b0;
      branch_s    = 1'b0;
      alusrc_s    = 1'b0;
      aluctl_s    = ALU_ADD;
      immsrc_s    = 2'b00;
      illegal_s   = 1'b0;
      use_rs1_s   = 1'b0;
      use_rs2_s   = 1'b0;
      case (op_s)
         OP_LW: begin
            regwrite_s  = 1'b1;
            resultsrc_s = 2'b01;
            alusrc_s    = 1'b1;
            use_rs1_s   = 1'b1;
         end
         OP_SW: begin
            memwrite_s = 1'b1;
            alusrc_s   = 1'b1;
            immsrc_s   = 2'b01;
            use_rs1_s  = 1'b1;
            use_rs2_s  = 1'b1;
         end
         OP_R: begin
            if (f3_ok_s) begin
               regwrite_s = 1'b1;
               use_rs1_s  = 1'b1;
               use_rs2_s  = 1'b1;
               if ((f3_s == 3'b000) && f7b5_s) begin
                  aluctl_s = ALU_SUB;
               end else begin
                  aluctl_s = alu_f3_s;
               end
            end else begin
               illegal_s = 1'b1;
            end
         end
         OP_I: begin
            if (f3_ok_s) begin
               regwrite_s = 1'b1;
               alusrc_s   = 1'b1;
               aluctl_s   = alu_f3_s;
               use_rs1_s  = 1'b1;
            end else begin
               illegal_s = 1'b1;
            end
         end
         OP_B: begin
            if (f3_s == 3'b000) begin
               branch_s  = 1'b1;
               immsrc_s  = 2'b10;
               aluctl_s  = ALU_SUB;
               use_rs1_s = 1'b1;
               use_rs2_s = 1'b1;
            end else begin
               illegal_s = 1'b1;
            end
         end
         OP_JAL: begin
            regwrite_s  = 1'b1;
            jump_s      = 1'b1;
            resultsrc_s = 2'b10;
            immsrc_s    = 2'b11;
         end
         default: illegal_s = 1'b1;
      endcase
   end

   // A load in E whose destination is read by D must wait one cycle
   assign lwstall_s = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                      ((use_rs1_s && (rs1_s == RdE)) || (use_rs2_s && (rs2_s == RdE)));
   assign flushe_s  = lwstall_s | PCSrcE;

   assign ImmSrcD  = immsrc_s;
   assign IllegalD = illegal_s;
   assign StallF   = lwstall_s;
   assign StallD   = lwstall_s;
   assign FlushD   = PCSrcE;
   assign FlushE   = flushe_s;

   // ID/EX control register: flushes and illegal instructions become bubbles
   always_ff @(posedge clk) begin
      if (reset || flushe_s || illegal_s) begin
         RegWriteE   <= 1'b0;
         ResultSrcE  <= 2'b00;
         MemWriteE   <= 1'b0;
         JumpE       <= 1'b0;
         BranchE     <= 1'b0;
         ALUSrcE     <= 1'b0;
         ALUControlE <= ALU_ADD;
         Rs1E        <= 5'd0;
         Rs2E        <= 5'd0;
         RdE         <= 5'd0;
      end else begin
         RegWriteE   <= regwrite_s;
         ResultSrcE  <= resultsrc_s;
         MemWriteE   <= memwrite_s;
         JumpE       <= jump_s;
         BranchE     <= branch_s;
         ALUSrcE     <= alusrc_s;
         ALUControlE <= aluctl_s;
         Rs1E        <= rs1_s;
         Rs2E        <= rs2_s;
         RdE         <= rd_s;
      end
   end

   // Illegal tracking: counts only when the instruction actually leaves D
   always_ff @(posedge clk) begin
      if (reset) begin
         IllegalSeen <= 1'b0;
         IllegalCnt  <= {ILLCNT_W{1'b0}};
      end else if (illegal_s && !flushe_s) begin
         IllegalSeen <= 1'b1;
         if (IllegalCnt != CNT_MAX) begin
            IllegalCnt <= IllegalCnt + ILLCNT_W'(1);
         end else begin
            IllegalCnt <= IllegalCnt;
         end
      end else begin
         IllegalSeen <= IllegalSeen;
         IllegalCnt  <= IllegalCnt;
      end
   end

endmodule
